// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the VGA raster generator.
// Defaults describe 640x480 @ 60 Hz with a 25 MHz pixel clock.
// Contents:
//   H_* / V_*          default porch, sync and visible widths
//   H_TOTAL, V_TOTAL   derived line and frame lengths
//   *_SYNC_START/END   derived sync windows, half-open [start, end)
//   coord_t            10-bit raster coordinate
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_VISIBLE + V_FRONT + V_SYNC;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping counter with enable plus its decodes.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   en             advance the count this cycle
//   count          registered position, 0..TOTAL-1
//   wrap           combinational: this edge takes count from TOTAL-1 to 0
//   sync_n         registered, low while count is in [SYNC_START, SYNC_END)
//   visible_next   combinational: the next count lies in [0, VISIBLE)
// Decodes are taken from the next count so that registered outputs line
// up with the registered count on the same cycle.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int VISIBLE    = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   en,
  output coord_t count,
  output logic   wrap,
  output logic   sync_n,
  output logic   visible_next
);

  localparam coord_t LAST    = coord_t'(TOTAL - 1);
  localparam coord_t VIS_LIM = coord_t'(VISIBLE);
  localparam coord_t SS      = coord_t'(SYNC_START);
  localparam coord_t SE      = coord_t'(SYNC_END);

  coord_t count_next;

  always_comb begin
    wrap       = en && (count == LAST);
    count_next = count;
    if (wrap) begin
      count_next = '0;
    end else if (en) begin
      count_next = count + 10'd1;
    end
    visible_next = (count_next < VIS_LIM);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count  <= '0;
      sync_n <= 1'b1;
    end else begin
      count  <= count_next;
      sync_n <= !((count_next >= SS) && (count_next < SE));
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel position, sync, blanking and
// frame-level pulses for the sprite/overlay renderers.
// Ports:
//   vga_clk        pixel clock, all state on its rising edge
//   reset_n        synchronous active-low reset
//   hs, vs         sync pulses, active low
//   blank          1 in the visible region, 0 in porch/sync
//   DrawX, DrawY   current raster position
//   line_start     one-cycle pulse when DrawX wraps to 0
//   frame_start    one-cycle pulse when (DrawX, DrawY) wraps to (0, 0)
//   frame_count    completed-frame counter, wraps 255 -> 0
// Every output is a register loaded from next-position decodes, so all of
// them describe the same (DrawX, DrawY) with no relative skew.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output coord_t     DrawX,
  output coord_t     DrawY,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Coordinates are 10 bits wide; larger modes cannot be represented.
  if (H_TOT > 1024 || V_TOT > 1024) begin : g_total_check
    $error("vga_timing_gen: line or frame total exceeds 1024");
  end

  logic h_wrap;
  logic v_wrap;
  logic h_vis_next;
  logic v_vis_next;

  vga_axis_counter #(
    .TOTAL      (H_TOT),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC)
  ) u_h_axis (
    .clk          (vga_clk),
    .reset_n      (reset_n),
    .en           (1'b1),
    .count        (DrawX),
    .wrap         (h_wrap),
    .sync_n       (hs),
    .visible_next (h_vis_next)
  );

  // The vertical axis steps once per line; its wrap flag therefore already
  // implies a horizontal wrap on the same edge.
  vga_axis_counter #(
    .TOTAL      (V_TOT),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC)
  ) u_v_axis (
    .clk          (vga_clk),
    .reset_n      (reset_n),
    .en           (h_wrap),
    .count        (DrawY),
    .wrap         (v_wrap),
    .sync_n       (vs),
    .visible_next (v_vis_next)
  );

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      blank       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      blank       <= h_vis_next && v_vis_next;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      if (v_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default-mode instance and one shrunken
// instance (15x11 raster) so frame wraps and the 8-bit frame counter
// rollover are reachable. Expected outputs come from an arithmetic model
// of the raster: after k counting edges since reset the position is
// k mod (H_TOTAL*V_TOTAL), split into x and y.
module tb_vga_timing_gen;

  // Shrunken mode: H 8+2+3+2 = 15, V 6+1+2+2 = 11, 165 clocks per frame.
  localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVV = 6, SVF = 1, SVS = 2, SVB = 2;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       d_hs, d_vs, d_blank, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;
  logic       s_hs, s_vs, s_blank, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  logic [7:0] s_fc;

  int checks = 0;
  int errors = 0;
  int k      = 0;   // counting edges since the last reset edge

  always #20 vga_clk = ~vga_clk;

  vga_timing_gen dut_d (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .hs          (d_hs),
    .vs          (d_vs),
    .blank       (d_blank),
    .DrawX       (d_x),
    .DrawY       (d_y),
    .line_start  (d_ls),
    .frame_start (d_fs),
    .frame_count (d_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE (SHV), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
    .V_VISIBLE (SVV), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB)
  ) dut_s (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .hs          (s_hs),
    .vs          (s_vs),
    .blank       (s_blank),
    .DrawX       (s_x),
    .DrawY       (s_y),
    .line_start  (s_ls),
    .frame_start (s_fs),
    .frame_count (s_fc)
  );

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // Raster model from the mode's widths and the edge count alone.
  task automatic model(input int hv, hf, hsw, hb, vv, vf, vsw, vb, input int kk,
                       output logic [9:0] ex, ey, output logic ehs, evs, ebl,
                       output logic els, efs, output logic [7:0] efc);
    int ht, vt, fr, p, x, y;
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    fr  = ht * vt;
    p   = kk % fr;
    x   = p % ht;
    y   = p / ht;
    ex  = 10'(x);
    ey  = 10'(y);
    ehs = !((x >= hv + hf) && (x < hv + hf + hsw));
    evs = !((y >= vv + vf) && (y < vv + vf + vsw));
    ebl = (x < hv) && (y < vv);
    els = (kk > 0) && (x == 0);
    efs = (kk > 0) && (p == 0);
    efc = 8'((kk / fr) % 256);
  endtask

  task automatic check_all();
    logic [9:0] ex, ey;
    logic       ehs, evs, ebl, els, efs;
    logic [7:0] efc;
    model(640, 16, 96, 48, 480, 10, 2, 33, k, ex, ey, ehs, evs, ebl, els, efs, efc);
    chk("def_x", d_x, ex);
    chk("def_y", d_y, ey);
    chk("def_hs", 10'(d_hs), 10'(ehs));
    chk("def_vs", 10'(d_vs), 10'(evs));
    chk("def_blank", 10'(d_blank), 10'(ebl));
    chk("def_line_start", 10'(d_ls), 10'(els));
    chk("def_frame_start", 10'(d_fs), 10'(efs));
    chk("def_frame_count", 10'(d_fc), 10'(efc));
    model(SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, k, ex, ey, ehs, evs, ebl, els, efs, efc);
    chk("sm_x", s_x, ex);
    chk("sm_y", s_y, ey);
    chk("sm_hs", 10'(s_hs), 10'(ehs));
    chk("sm_vs", 10'(s_vs), 10'(evs));
    chk("sm_blank", 10'(s_blank), 10'(ebl));
    chk("sm_line_start", 10'(s_ls), 10'(els));
    chk("sm_frame_start", 10'(s_fs), 10'(efs));
    chk("sm_frame_count", 10'(s_fc), 10'(efc));
  endtask

  // Drive reset level for one edge, advance the model, sample 1 ns later.
  task automatic step(input logic rn);
    reset_n = rn;
    @(posedge vga_clk);
    if (rn) k = k + 1;
    else    k = 0;
    #1;
    check_all();
  endtask

  initial begin
    // Reset hold, then random run lengths with random mid-frame resets.
    for (int i = 0; i < 5; i++) step(1'b0);
    for (int r = 0; r < 8; r++) begin
      int run_len, rst_len;
      run_len = int'($urandom_range(1, 700));
      rst_len = int'($urandom_range(1, 3));
      for (int i = 0; i < run_len; i++) step(1'b1);
      for (int i = 0; i < rst_len; i++) step(1'b0);
    end
    // Long run from reset: over 256 shrunken frames (counter rollover)
    // and ~53 default lines (hs window, line wraps, DrawY stepping).
    for (int i = 0; i < 42500; i++) step(1'b1);
    // One-cycle reset at a random point, then a short tail.
    for (int i = 0; i < int'($urandom_range(1, 400)); i++) step(1'b1);
    step(1'b0);
    for (int i = 0; i < 400; i++) step(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
